// File: rtl/fast_square_sweep_ctrl.sv
// Sweep sequencer for a square-wave receiver. It resets the receiver, then for each frequency step
// it waits a settle gap, records, and pulses freq_step. All outputs come straight from flops.
module fast_square_sweep_ctrl #(
   parameter logic [6:0] CTRLADDR   = 7'd3,
   parameter logic [6:0] RECLENADDR = 7'd4,
   parameter logic [6:0] GAPLENADDR = 7'd5,
   parameter logic [6:0] NSTEPSADDR = 7'd6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [6:0]  serial_addr,
   input  logic [31:0] serial_data,
   input  logic        serial_strobe,
   input  logic        trigger,
   output logic        rx_reset,
   output logic        record,
   output logic        freq_step,
   output logic        busy,
   output logic        sweep_done,
   output logic [7:0]  step_index
);

   // state  | meaning
   // IDLE   | waiting for trigger or sw_start with enable set
   // RXRST  | receiver reset held for two cycles
   // SETTLE | gap_len cycles with record low
   // RECORD | record_len cycles with record high
   // STEP   | one-cycle freq_step pulse
   // DONE   | one-cycle sweep_done pulse
   typedef enum logic [2:0] {
      S_IDLE, S_RXRST, S_SETTLE, S_RECORD, S_STEP, S_DONE
   } state_t;

   state_t      state, state_nxt;
   logic        enable, continuous;
   logic [15:0] record_len, gap_len;
   logic [7:0]  num_steps;
   logic [15:0] rec_snap, gap_snap;
   logic [7:0]  steps_snap;
   logic [15:0] cnt, cnt_nxt;
   logic [7:0]  idx_nxt;
   logic        snap;
   logic        ctrl_wr, sw_start, enable_eff, cont_eff;

   assign ctrl_wr    = serial_strobe && (serial_addr == CTRLADDR);
   assign sw_start   = ctrl_wr && serial_data[2];
   // A write clearing enable takes effect on the same edge it is written.
   assign enable_eff = ctrl_wr ? serial_data[0] : enable;
   assign cont_eff   = ctrl_wr ? serial_data[1] : continuous;

   always_ff @(posedge clock) begin
      if (reset) begin
         enable     <= 1'b0;
         continuous <= 1'b0;
         record_len <= 16'd16384;
         gap_len    <= 16'd0;
         num_steps  <= 8'd4;
      end else if (serial_strobe) begin
         if (serial_addr == CTRLADDR) begin
            enable     <= serial_data[0];
            continuous <= serial_data[1];
         end
         if (serial_addr == RECLENADDR) record_len <= serial_data[15:0];
         if (serial_addr == GAPLENADDR) gap_len    <= serial_data[15:0];
         if (serial_addr == NSTEPSADDR) num_steps  <= serial_data[7:0];
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = step_index;
      snap      = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable_eff && (trigger || sw_start)) begin
               state_nxt = S_RXRST;
               cnt_nxt   = 16'd1;
               idx_nxt   = 8'd0;
               snap      = 1'b1;
            end
         end
         S_RXRST: begin
            if (cnt == 16'd0) begin
               idx_nxt = 8'd0;
               if (gap_snap == 16'd0) begin
                  state_nxt = S_RECORD;
                  cnt_nxt   = rec_snap - 16'd1;
               end else begin
                  state_nxt = S_SETTLE;
                  cnt_nxt   = gap_snap - 16'd1;
               end
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         S_SETTLE: begin
            if (cnt == 16'd0) begin
               state_nxt = S_RECORD;
               cnt_nxt   = rec_snap - 16'd1;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         S_RECORD: begin
            if (cnt == 16'd0) state_nxt = S_STEP;
            else              cnt_nxt   = cnt - 16'd1;
         end
         S_STEP: begin
            if (step_index == steps_snap - 8'd1) begin
               state_nxt = S_DONE;
            end else begin
               idx_nxt = step_index + 8'd1;
               if (gap_snap == 16'd0) begin
                  state_nxt = S_RECORD;
                  cnt_nxt   = rec_snap - 16'd1;
               end else begin
                  state_nxt = S_SETTLE;
                  cnt_nxt   = gap_snap - 16'd1;
               end
            end
         end
         S_DONE: begin
            if (enable_eff && cont_eff) begin
               state_nxt = S_RXRST;
               cnt_nxt   = 16'd1;
               idx_nxt   = 8'd0;
               snap      = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (state != S_IDLE && !enable_eff) begin
         state_nxt = S_IDLE;
         cnt_nxt   = cnt;
         idx_nxt   = step_index;
         snap      = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= 16'd0;
         step_index <= 8'd0;
         rec_snap   <= 16'd1;
         gap_snap   <= 16'd0;
         steps_snap <= 8'd1;
         rx_reset   <= 1'b1;
         record     <= 1'b0;
         freq_step  <= 1'b0;
         busy       <= 1'b0;
         sweep_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         step_index <= idx_nxt;
         if (snap) begin
            rec_snap   <= (record_len == 16'd0) ? 16'd1 : record_len;
            gap_snap   <= gap_len;
            steps_snap <= (num_steps == 8'd0) ? 8'd1 : num_steps;
         end
         rx_reset   <= (state_nxt == S_RXRST);
         record     <= (state_nxt == S_RECORD);
         freq_step  <= (state_nxt == S_STEP);
         busy       <= (state_nxt != S_IDLE);
         sweep_done <= (state_nxt == S_DONE);
      end
   end

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Bench for fast_square_sweep_ctrl: stimulus pushes the expected pulse trace of each sweep into a
// queue and a negedge monitor pops one entry for every cycle in which a pulse output is high.
module tb_fast_square_sweep_ctrl;

   localparam int NOSTOP = 32'h7fff_ffff;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  serial_addr = 7'd0;
   logic [31:0] serial_data = 32'd0;
   logic        serial_strobe = 1'b0;
   logic        trigger = 1'b0;
   logic        rx_reset, record, freq_step, busy, sweep_done;
   logic [7:0]  step_index;

   typedef struct {
      int         cyc;
      logic [3:0] outs;
      int         idx;
   } ev_t;

   ev_t  q[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   logic rst_seen = 1'b1;

   fast_square_sweep_ctrl dut (
      .clock(clock), .reset(reset),
      .serial_addr(serial_addr), .serial_data(serial_data), .serial_strobe(serial_strobe),
      .trigger(trigger), .rx_reset(rx_reset), .record(record), .freq_step(freq_step),
      .busy(busy), .sweep_done(sweep_done), .step_index(step_index)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge clock) rst_seen <= reset;

   always @(negedge clock) begin
      logic [3:0] obs;
      ev_t e;
      obs = {rx_reset, record, freq_step, sweep_done};
      if (!rst_seen && obs != 4'b0000) begin
         n_tests++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse cyc=%0d outs=%b idx=%0d required no pulse", cyc, obs, step_index);
         end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.outs != obs || (e.idx >= 0 && e.idx != int'(step_index))) begin
               n_fail++;
               $display("FAIL pulse_trace got cyc=%0d outs=%b idx=%0d required cyc=%0d outs=%b idx=%0d",
                        cyc, obs, step_index, e.cyc, e.outs, e.idx);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_until(input int c);
      int budget = 5000;
      while (cyc < c && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_budget got cyc=%0d required %0d", cyc, c);
      end
   endtask

   task automatic wr(input logic [6:0] a, input logic [31:0] d);
      serial_addr   = a;
      serial_data   = d;
      serial_strobe = 1'b1;
      tick();
      serial_strobe = 1'b0;
   endtask

   task automatic fire(output int t);
      trigger = 1'b1;
      t = cyc;
      tick();
      trigger = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic push(input int c, input logic [3:0] o, input int idx, input int stop);
      ev_t e;
      if (c < stop) begin
         e.cyc = c; e.outs = o; e.idx = idx;
         q.push_back(e);
      end
   endtask

   // Expected trace of one sweep whose start was sampled in cycle t; done_c is the sweep_done cycle.
   task automatic push_sweep(input int t, input int gap, input int rec, input int steps,
                             input int stop, output int done_c);
      int c, r, s;
      r = (rec == 0) ? 1 : rec;
      s = (steps == 0) ? 1 : steps;
      push(t + 1, 4'b1000, 0, stop);
      push(t + 2, 4'b1000, 0, stop);
      c = t + 3;
      for (int k = 0; k < s; k++) begin
         c += gap;
         for (int j = 0; j < r; j++) begin
            push(c, 4'b0100, k, stop);
            c++;
         end
         push(c, 4'b0010, k, stop);
         c++;
      end
      push(c, 4'b0001, s - 1, stop);
      done_c = c;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rx_reset"}, 32'(rx_reset), 32'd1);
      chk({tag, "_record"}, 32'(record), 32'd0);
      chk({tag, "_freq_step"}, 32'(freq_step), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_sweep_done"}, 32'(sweep_done), 32'd0);
      chk({tag, "_step_index"}, 32'(step_index), 32'd0);
   endtask

   initial begin
      int t, d, d2;

      // Reset state and rx_reset release
      tick(); tick(); tick();
      chk_reset_outputs("reset");
      reset = 1'b0;
      tick();
      chk("rx_reset_release", 32'(rx_reset), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // Trigger with enable still 0 after reset must be ignored
      fire(t);
      wait_until(t + 6);
      chk("disabled_busy", 32'(busy), 32'd0);

      // Basic sweep: rec=4 gap=2 steps=2
      wr(7'd1 + 7'd2, 32'd1);
      wr(7'd4, 32'd4);
      wr(7'd5, 32'd2);
      wr(7'd6, 32'd2);
      fire(t);
      push_sweep(t, 2, 4, 2, NOSTOP, d);
      chk("basic_done_cycle", 32'(d - t), 32'd17);
      wait_until(t + 17);
      chk("basic_busy_in_done", 32'(busy), 32'd1);
      tick();
      chk("basic_busy_after", 32'(busy), 32'd0);

      // Zero lengths: gap=0, rec=0 -> 1, steps=0 -> 1; upper data bits ignored
      wr(7'd4, 32'hABCD_0000);
      wr(7'd5, 32'h1234_0000);
      wr(7'd6, 32'hFFFF_FF00);
      fire(t);
      push_sweep(t, 0, 0, 0, NOSTOP, d);
      wait_until(d + 1);
      chk("zero_busy_after", 32'(busy), 32'd0);

      // Continuous: two back-to-back sweeps, continuous cleared during the second
      wr(7'd4, 32'd2);
      wr(7'd5, 32'd1);
      wr(7'd6, 32'd3);
      wr(7'd3, 32'd3);
      fire(t);
      push_sweep(t, 1, 2, 3, NOSTOP, d);
      push_sweep(d, 1, 2, 3, NOSTOP, d2);
      wait_until(d + 1);
      chk("cont_rx_reset_restart", 32'(rx_reset), 32'd1);
      chk("cont_index_zero", 32'(step_index), 32'd0);
      wait_until(d + 4);
      wr(7'd3, 32'd1);
      wait_until(d2 + 1);
      chk("cont_busy_after", 32'(busy), 32'd0);

      // Enable cleared during RECORD of step 1
      wr(7'd4, 32'd4);
      wr(7'd6, 32'd3);
      fire(t);
      push_sweep(t, 1, 4, 3, t + 12, d);
      wait_until(t + 11);
      wr(7'd3, 32'd0);
      chk("abort_record_low", 32'(record), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      wait_until(t + 25);
      chk("abort_index_held", 32'(step_index), 32'd1);
      chk("abort_busy_later", 32'(busy), 32'd0);

      // Mid-sweep record_len rewrite, trigger and sw_start while busy
      wr(7'd3, 32'd1);
      wr(7'd4, 32'd6);
      wr(7'd5, 32'd0);
      wr(7'd6, 32'd2);
      fire(t);
      push_sweep(t, 0, 6, 2, NOSTOP, d);
      wait_until(t + 4);
      wr(7'd4, 32'd8);
      wait_until(t + 6);
      fire(d2);
      wait_until(t + 8);
      wr(7'd3, 32'd5);
      wait_until(d + 1);
      chk("rewrite_busy_after", 32'(busy), 32'd0);
      wr(7'd3, 32'd5);
      t = cyc - 1;
      push_sweep(t, 0, 8, 2, NOSTOP, d);
      wait_until(d + 1);
      chk("new_len_busy_after", 32'(busy), 32'd0);

      // Reset asserted during STEP
      wr(7'd4, 32'd2);
      wr(7'd5, 32'd1);
      fire(t);
      push_sweep(t, 1, 2, 2, t + 7, d);
      wait_until(t + 6);
      chk("pre_reset_freq_step", 32'(freq_step), 32'd1);
      reset = 1'b1;
      tick();
      chk_reset_outputs("mid_reset");
      reset = 1'b0;
      tick();

      // Register defaults after reset: enable 0, gap 0, steps 4
      fire(t);
      wait_until(t + 5);
      chk("default_disabled_busy", 32'(busy), 32'd0);
      wr(7'd3, 32'd1);
      wr(7'd4, 32'd1);
      fire(t);
      push_sweep(t, 0, 1, 4, NOSTOP, d);
      wait_until(d + 1);
      chk("default_busy_after", 32'(busy), 32'd0);

      tick(); tick();
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
